// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 interrupt front end: source count,
// source-id encoding and priority constants.
package cp0_pkg;

  localparam int NSRC        = 3;
  localparam int SRC_ID_W    = 2;
  localparam int STACK_DEPTH = 3;
  localparam int DBNC_CNT_W  = 8;

  // Priority equals the source id; higher id wins.
  localparam logic [SRC_ID_W-1:0] PRI_SRC0 = 2'd0;
  localparam logic [SRC_ID_W-1:0] PRI_SRC1 = 2'd1;
  localparam logic [SRC_ID_W-1:0] PRI_SRC2 = 2'd2;

  function automatic logic [SRC_ID_W-1:0] onehot_to_id(input logic [NSRC-1:0] oh);
    logic [SRC_ID_W-1:0] id;
    id = PRI_SRC0;
    if (oh[2])      id = PRI_SRC2;
    else if (oh[1]) id = PRI_SRC1;
    return id;
  endfunction

  function automatic logic [NSRC-1:0] id_to_onehot(input logic [SRC_ID_W-1:0] id);
    return NSRC'(1) << id;
  endfunction

endpackage

// File: rtl/irq_sync_debounce.sv
// One raw interrupt line: multi-flop synchronizer, saturating debounce counter
// and a single-cycle accepted-edge pulse.
module irq_sync_debounce
  import cp0_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic edge_pulse
);

  localparam logic [DBNC_CNT_W-1:0] CNT_MAX = DBNC_CNT_W'(DEBOUNCE);
  localparam logic [DBNC_CNT_W-1:0] CNT_ARM = DBNC_CNT_W'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [DBNC_CNT_W-1:0]  cnt;
  logic                   synced;

  assign synced = sync_p[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p <= '0;
      cnt    <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
      if (!synced)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + DBNC_CNT_W'(1);
    end
  end

  // Fires on the cycle the counter steps onto DEBOUNCE; saturation keeps a
  // held line from firing again until it has been seen low.
  assign edge_pulse = synced && (cnt == CNT_ARM);

endmodule

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: debounced sources, pending latch, fixed-priority
// filter against the in-service stack, and stack push/pop from CP0 feedback.
module irq_source_ctrl
  import cp0_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_raw,
  input  logic            has_exp,
  input  logic            eret,
  output logic [NSRC-1:0] exp_src,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic [1:0]      depth,
  output logic            err
);

  logic [NSRC-1:0]     edges;
  logic [SRC_ID_W-1:0] stk [STACK_DEPTH];

  logic [NSRC-1:0]     insvc, insvc_pp;
  logic [NSRC-1:0]     grant, grant_pp;
  logic [NSRC-1:0]     pop_mask, pend_pp;
  logic [SRC_ID_W-1:0] top_id, top_pp;
  logic [1:0]          depth_pp;
  logic                do_pop, do_push, err_set;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_sync_debounce #(
      .DEBOUNCE    (DEBOUNCE),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_dbnc (
      .clk        (clk),
      .reset      (reset),
      .raw        (irq_raw[g]),
      .edge_pulse (edges[g])
    );
  end

  // Highest pending source above the running handler's priority.
  function automatic logic [NSRC-1:0] pick_grant(
    input logic [NSRC-1:0]     pend,
    input logic [NSRC-1:0]     svc,
    input logic [1:0]          dep,
    input logic [SRC_ID_W-1:0] topid
  );
    logic [NSRC-1:0] g;
    g = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (g == '0 && pend[i] && !svc[i] &&
          (dep == 2'd0 || SRC_ID_W'(i) > topid))
        g[i] = 1'b1;
    end
    return g;
  endfunction

  always_comb begin
    do_pop   = eret && (depth != 2'd0);
    depth_pp = do_pop ? depth - 2'd1 : depth;
    top_id   = (depth == 2'd0)    ? PRI_SRC0 : stk[depth - 2'd1];
    top_pp   = (depth_pp == 2'd0) ? PRI_SRC0 : stk[depth_pp - 2'd1];
    pop_mask = do_pop ? id_to_onehot(top_id) : '0;
    pend_pp  = pending & ~pop_mask;
  end

  always_comb begin
    insvc    = '0;
    insvc_pp = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (2'(i) < depth)    insvc    = insvc    | id_to_onehot(stk[i]);
      if (2'(i) < depth_pp) insvc_pp = insvc_pp | id_to_onehot(stk[i]);
    end
  end

  // A push in the same cycle as a pop is judged against the post-pop state.
  always_comb begin
    grant    = pick_grant(pending, insvc, depth, top_id);
    grant_pp = pick_grant(pend_pp, insvc_pp, depth_pp, top_pp);
    do_push  = has_exp && (grant_pp != '0) && (depth_pp != 2'(STACK_DEPTH));
    err_set  = (eret && depth == 2'd0) ||
               (has_exp && (grant_pp == '0 || depth_pp == 2'(STACK_DEPTH)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      depth   <= '0;
      err     <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else begin
      // An edge landing on the pop of its own source keeps it pending.
      pending <= pend_pp | edges;
      if (do_push) stk[depth_pp] <= onehot_to_id(grant_pp);
      depth <= depth_pp + (do_push ? 2'd1 : 2'd0);
      if (err_set) err <= 1'b1;
    end
  end

  assign exp_src    = grant;
  assign in_service = insvc;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl with a cycle-tagged scoreboard.
module tb_irq_source_ctrl;
  import cp0_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] irq_raw;
  logic       has_exp;
  logic       eret;
  logic [2:0] exp_src, pending, in_service;
  logic [1:0] depth;
  logic       err;

  irq_source_ctrl #(.DEBOUNCE(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_raw    (irq_raw),
    .has_exp    (has_exp),
    .eret       (eret),
    .exp_src    (exp_src),
    .pending    (pending),
    .in_service (in_service),
    .depth      (depth),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       name;
    logic [11:0] exp;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;

  // Expected {err, depth, in_service, pending, exp_src} observed at the
  // falling edge of cycle cyc+off.
  task automatic expect_st(input int off, input string name,
                           input logic [2:0] p, input logic [2:0] x,
                           input logic [2:0] s, input logic [1:0] d,
                           input logic e);
    sb_t ent;
    ent.at   = cyc + off;
    ent.name = name;
    ent.exp  = {e, d, s, p, x};
    sb.push_back(ent);
  endtask

  always @(negedge clk) begin
    logic [11:0] act;
    act = {err, depth, in_service, pending, exp_src};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        checks++;
        if (sb[i].at != cyc || act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d: got err=%b depth=%0d in_service=%b pending=%b exp_src=%b, want err=%b depth=%0d in_service=%b pending=%b exp_src=%b",
                   sb[i].name, cyc, act[11], act[10:9], act[8:6], act[5:3], act[2:0],
                   sb[i].exp[11], sb[i].exp[10:9], sb[i].exp[8:6], sb[i].exp[5:3], sb[i].exp[2:0]);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise a line long enough to be accepted, then drop it.
  task automatic fire(input int k);
    irq_raw[k] = 1'b1;
    tick(6);
    irq_raw[k] = 1'b0;
  endtask

  task automatic pulse_exp();
    has_exp = 1'b1;
    tick(1);
    has_exp = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    irq_raw = '0;
    has_exp = 1'b0;
    eret    = 1'b0;
    tick(2);
    expect_st(0, "reset_state", 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // Latency: accepted exactly SYNC_STAGES+DEBOUNCE edges after the rise.
    irq_raw[0] = 1'b1;
    expect_st(5, "latency_before", 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    expect_st(6, "latency_set",    3'b001, 3'b001, 3'b000, 2'd0, 1'b0);
    tick(10);
    irq_raw[0] = 1'b0;
    expect_st(0, "held_line",      3'b001, 3'b001, 3'b000, 2'd0, 1'b0);

    pulse_exp();
    expect_st(0, "push0",          3'b001, 3'b000, 3'b001, 2'd1, 1'b0);
    pulse_eret();
    expect_st(0, "pop0",           3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

    irq_raw[0] = 1'b1;
    tick(3);
    irq_raw[0] = 1'b0;
    tick(8);
    expect_st(0, "glitch",         3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

    // Nesting
    fire(0);
    expect_st(0, "nest_src0",      3'b001, 3'b001, 3'b000, 2'd0, 1'b0);
    pulse_exp();
    expect_st(0, "nest_push0",     3'b001, 3'b000, 3'b001, 2'd1, 1'b0);
    fire(2);
    expect_st(0, "nest_src2",      3'b101, 3'b100, 3'b001, 2'd1, 1'b0);
    pulse_exp();
    expect_st(0, "nest_push2",     3'b101, 3'b000, 3'b101, 2'd2, 1'b0);
    fire(1);
    expect_st(0, "nest_src1_mask", 3'b111, 3'b000, 3'b101, 2'd2, 1'b0);
    pulse_eret();
    expect_st(0, "nest_pop2",      3'b011, 3'b010, 3'b001, 2'd1, 1'b0);
    pulse_eret();
    expect_st(0, "nest_pop0",      3'b010, 3'b010, 3'b000, 2'd0, 1'b0);

    // Same-cycle eret + has_exp
    pulse_exp();
    expect_st(0, "sc_push1",       3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
    fire(2);
    expect_st(0, "sc_src2",        3'b110, 3'b100, 3'b010, 2'd1, 1'b0);
    has_exp = 1'b1;
    eret    = 1'b1;
    tick(1);
    has_exp = 1'b0;
    eret    = 1'b0;
    expect_st(0, "sc_pop_push",    3'b100, 3'b000, 3'b100, 2'd1, 1'b0);
    pulse_eret();
    expect_st(0, "sc_pop2",        3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

    // Edge on source 1 landing on the pop of source 1
    fire(1);
    pulse_exp();
    expect_st(0, "ew_push1",       3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
    irq_raw[1] = 1'b1;
    expect_st(5, "ew_pre_pop",     3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
    tick(5);
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
    irq_raw[1] = 1'b0;
    expect_st(0, "ew_edge_wins",   3'b010, 3'b010, 3'b000, 2'd0, 1'b0);
    tick(1);
    expect_st(0, "ew_regrant",     3'b010, 3'b010, 3'b000, 2'd0, 1'b0);
    pulse_exp();
    pulse_eret();
    expect_st(0, "ew_clear",       3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

    // Protocol errors
    pulse_eret();
    expect_st(0, "err_eret_empty", 3'b000, 3'b000, 3'b000, 2'd0, 1'b1);
    tick(3);
    expect_st(0, "err_sticky",     3'b000, 3'b000, 3'b000, 2'd0, 1'b1);
    fire(0);
    pulse_exp();
    expect_st(0, "err_push0",      3'b001, 3'b000, 3'b001, 2'd1, 1'b1);
    pulse_exp();
    expect_st(0, "err_no_grant",   3'b001, 3'b000, 3'b001, 2'd1, 1'b1);
    pulse_eret();
    expect_st(0, "err_pop0",       3'b000, 3'b000, 3'b000, 2'd0, 1'b1);

    // Async reset at depth 2 with source 1 mid-debounce
    fire(0);
    pulse_exp();
    fire(2);
    pulse_exp();
    expect_st(0, "rst_depth2",     3'b101, 3'b000, 3'b101, 2'd2, 1'b1);
    irq_raw[1] = 1'b1;
    tick(2);
    #2;
    reset = 1'b0;
    expect_st(0, "async_reset",    3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    tick(1);
    reset = 1'b1;
    expect_st(5, "restart_wait",   3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    expect_st(6, "restart_edge",   3'b010, 3'b010, 3'b000, 2'd0, 1'b0);
    tick(7);
    irq_raw[1] = 1'b0;
    tick(2);

    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
